// File: rtl/bdiff_pkg.sv
// Shared types and helpers for the Boolean-difference sweep sequencer.
package bdiff_pkg;

   localparam int N_VARS_DEF = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_EMIT   = 3'd3,
      ST_DONE   = 3'd4
   } bdiff_state_e;

   // Counter must hold 0 .. SETTLE_CYCLES.
   function automatic int settle_cnt_w(input int settle);
      return (settle < 1) ? 1 : $clog2(settle + 1);
   endfunction

endpackage

// File: rtl/bdiff_settle_timer.sv
// Settle-time counter: cleared by load, counts while enabled, expire on the last hold cycle.
module bdiff_settle_timer
   import bdiff_pkg::*;
#(
   parameter int COUNT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam int W = settle_cnt_w(COUNT);

   logic [W-1:0] cnt;

   assign expire = (cnt == W'(COUNT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                cnt <= '0;
      else if (load)          cnt <= '0;
      else if (en && !expire) cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/bdiff_sweep_ctrl.sv
// Walks an external combinational evaluator through every input vector and
// streams the vectors that evaluate to 1 over a valid/ready port.
module bdiff_sweep_ctrl
   import bdiff_pkg::*;
#(
   parameter int N_VARS        = N_VARS_DEF,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [N_VARS-1:0] vec_out,
   input  logic              f_in,
   output logic              match_valid,
   input  logic              match_ready,
   output logic [N_VARS-1:0] match_data,
   output logic [N_VARS:0]   match_count,
   output logic              busy,
   output logic              done,
   output logic              none_found
);

   bdiff_state_e state;
   logic         last_vec, xfer, advance, tmr_load, tmr_expire;

   assign last_vec    = &vec_out;
   assign xfer        = (state == ST_EMIT) && match_ready;
   assign advance     = ((state == ST_SAMPLE) && !f_in && !last_vec) || (xfer && !last_vec);
   assign tmr_load    = ((state == ST_IDLE) && start) || advance;

   assign match_valid = (state == ST_EMIT);
   assign busy        = (state != ST_IDLE);
   assign done        = (state == ST_DONE);

   bdiff_settle_timer #(.COUNT(SETTLE_CYCLES)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (tmr_load),
      .en     (state == ST_APPLY),
      .expire (tmr_expire)
   );

   // none_found is resolved on entry to DONE so it is valid alongside the done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         vec_out     <= '0;
         match_data  <= '0;
         match_count <= '0;
         none_found  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               vec_out     <= '0;
               match_count <= '0;
               none_found  <= 1'b0;
               state       <= ST_APPLY;
            end
            ST_APPLY: if (tmr_expire) state <= ST_SAMPLE;
            ST_SAMPLE: begin
               if (f_in) begin
                  match_data <= vec_out;
                  state      <= ST_EMIT;
               end else if (last_vec) begin
                  none_found <= (match_count == '0);
                  state      <= ST_DONE;
               end else begin
                  vec_out    <= vec_out + 1'b1;
                  state      <= ST_APPLY;
               end
            end
            ST_EMIT: if (match_ready) begin
               match_count <= match_count + 1'b1;
               if (last_vec) begin
                  none_found <= 1'b0;
                  state      <= ST_DONE;
               end else begin
                  vec_out    <= vec_out + 1'b1;
                  state      <= ST_APPLY;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bdiff_sweep_ctrl.sv
// Bench for bdiff_sweep_ctrl: table-driven evaluators, ready stall patterns, reference sweep model.
module tb_bdiff_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] start_v = 2'b00;
   logic [1:0] ready_v = 2'b11;
   logic [7:0] tt_a = 8'h00;
   logic [7:0] tt_b = 8'h00;
   int         n_chk = 0;
   int         n_fail = 0;

   logic [2:0] vec_a, vec_b, data_a, data_b;
   logic [3:0] cnt_a, cnt_b;
   logic       val_a, val_b, busy_a, busy_b, done_a, done_b, nf_a, nf_b;
   logic       f_a, f_b;

   always #5 clk = ~clk;

   // Evaluators are truth tables indexed by {Cin,A,B}.
   assign f_a = tt_a[vec_a];
   assign f_b = tt_b[vec_b];

   bdiff_sweep_ctrl #(.N_VARS(3), .SETTLE_CYCLES(1)) u_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .vec_out(vec_a), .f_in(f_a),
      .match_valid(val_a), .match_ready(ready_v[0]), .match_data(data_a),
      .match_count(cnt_a), .busy(busy_a), .done(done_a), .none_found(nf_a)
   );

   bdiff_sweep_ctrl #(.N_VARS(3), .SETTLE_CYCLES(3)) u_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .vec_out(vec_b), .f_in(f_b),
      .match_valid(val_b), .match_ready(ready_v[1]), .match_data(data_b),
      .match_count(cnt_b), .busy(busy_b), .done(done_b), .none_found(nf_b)
   );

   logic [2:0] o_vec[2], o_data[2];
   logic [3:0] o_cnt[2];
   logic       o_val[2], o_busy[2], o_done[2], o_nf[2];
   assign o_vec[0]  = vec_a;  assign o_vec[1]  = vec_b;
   assign o_data[0] = data_a; assign o_data[1] = data_b;
   assign o_cnt[0]  = cnt_a;  assign o_cnt[1]  = cnt_b;
   assign o_val[0]  = val_a;  assign o_val[1]  = val_b;
   assign o_busy[0] = busy_a; assign o_busy[1] = busy_b;
   assign o_done[0] = done_a; assign o_done[1] = done_b;
   assign o_nf[0]   = nf_a;   assign o_nf[1]   = nf_b;

   // (A^B) & dCout/dCin for a full adder, computed from the carry equation.
   function automatic logic [7:0] ref_table();
      logic [7:0] r;
      logic a, b, c0, c1;
      for (int v = 0; v < 8; v++) begin
         a  = v[1]; b = v[0];
         c0 = (a & b) | (1'b0 & (a ^ b));
         c1 = (a & b) | (1'b1 & (a ^ b));
         r[v] = (a ^ b) & (c0 ^ c1);
      end
      return r;
   endfunction

   // pol: 0 ready high, 1 three stall cycles per match, 2 random stalls.
   task automatic run_sweep(input int sel, input int s, input logic [7:0] tt,
                            input int pol, input bit poke, input string name);
      int exp_q[$];
      int got_q[$];
      int stall[8];
      int hold[8];
      int exp_done, t, mi, st, run, nm, lim;
      logic [2:0] cur, prev_data;
      logic prev_stall, rdy;
      bit fin, seen_done;
      nm = 0; exp_done = 0;
      for (int v = 0; v < 8; v++) begin
         hold[v] = s + 1;
         if (tt[v]) begin
            stall[nm] = (pol == 0) ? 0 : (pol == 1) ? 3 : int'($urandom_range(0, 3));
            hold[v] += 1 + stall[nm];
            exp_q.push_back(v);
            nm++;
         end
         exp_done += hold[v];
      end
      if (sel == 0) tt_a = tt; else tt_b = tt;
      ready_v[sel] = 1'b1;
      @(negedge clk); start_v[sel] = 1'b1;
      @(negedge clk); start_v[sel] = 1'b0;
      n_chk++;
      if (o_busy[sel] !== 1'b1 || o_vec[sel] !== 3'd0) begin
         n_fail++; $display("FAIL %s start: busy=%b vec=%b, need busy=1 vec=000", name, o_busy[sel], o_vec[sel]);
      end
      cur = 3'd0; run = 0; mi = 0; st = 0; prev_stall = 1'b0; prev_data = 3'd0;
      fin = 1'b0; seen_done = 1'b0; t = 0;
      while (!fin) begin
         start_v[sel] = poke && (t == 5);
         if (o_done[sel] === 1'b1) begin
            fin = 1'b1; seen_done = 1'b1;
            n_chk++;
            if (t != exp_done) begin
               n_fail++; $display("FAIL %s done_time: got %0d, need %0d", name, t, exp_done);
            end
            n_chk++;
            if (cur !== 3'd7 || run != hold[7]) begin
               n_fail++; $display("FAIL %s last_hold: vec=%0d run=%0d, need vec=7 run=%0d", name, cur, run, hold[7]);
            end
         end else if (t >= 600) begin
            fin = 1'b1;
            n_chk++; n_fail++;
            $display("FAIL %s timeout: no done after %0d cycles, need %0d", name, t, exp_done);
         end else begin
            if (o_vec[sel] !== cur) begin
               n_chk++;
               if (run != hold[cur] || o_vec[sel] !== cur + 3'd1) begin
                  n_fail++;
                  $display("FAIL %s hold: vec %0d held %0d then %0d, need %0d then %0d",
                           name, cur, run, o_vec[sel], hold[cur], cur + 3'd1);
               end
               cur = o_vec[sel]; run = 1;
            end else run++;
            if (o_val[sel] === 1'b1) begin
               if (prev_stall) begin
                  n_chk++;
                  if (o_data[sel] !== prev_data) begin
                     n_fail++; $display("FAIL %s data_stable: got %b, need %b", name, o_data[sel], prev_data);
                  end
               end
               lim = (mi < nm) ? stall[mi] : 0;
               if (st < lim) begin
                  rdy = 1'b0; st++; prev_stall = 1'b1; prev_data = o_data[sel];
               end else begin
                  rdy = 1'b1; got_q.push_back(int'(o_data[sel])); mi++; st = 0; prev_stall = 1'b0;
               end
            end else begin
               if (prev_stall) begin
                  n_chk++; n_fail++;
                  $display("FAIL %s valid_drop: valid=0 without transfer, need 1", name);
               end
               prev_stall = 1'b0;
               rdy = (pol == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            ready_v[sel] = rdy;
            @(negedge clk);
            t++;
         end
      end
      ready_v[sel] = 1'b1;
      start_v[sel] = poke;
      @(negedge clk);
      start_v[sel] = 1'b0;
      if (seen_done) begin
         n_chk++;
         if (o_done[sel] !== 1'b0 || o_busy[sel] !== 1'b0) begin
            n_fail++; $display("FAIL %s post_done: done=%b busy=%b, need 0 0", name, o_done[sel], o_busy[sel]);
         end
         n_chk++;
         if (o_cnt[sel] !== 4'(nm) || o_nf[sel] !== (nm == 0)) begin
            n_fail++; $display("FAIL %s count: count=%0d nf=%b, need %0d %b", name, o_cnt[sel], o_nf[sel], nm, nm == 0);
         end
      end
      @(negedge clk);
      n_chk++;
      if (o_busy[sel] !== 1'b0 || o_cnt[sel] !== 4'(nm)) begin
         n_fail++; $display("FAIL %s idle_hold: busy=%b count=%0d, need 0 %0d", name, o_busy[sel], o_cnt[sel], nm);
      end
      n_chk++;
      if (got_q != exp_q) begin
         n_fail++; $display("FAIL %s match_seq: got %p, need %p", name, got_q, exp_q);
      end
   endtask

   task automatic test_reset();
      #12;
      for (int i = 0; i < 2; i++) begin
         n_chk++;
         if ({o_vec[i], o_data[i], o_cnt[i], o_val[i], o_busy[i], o_done[i], o_nf[i]} !== 17'd0) begin
            n_fail++; $display("FAIL reset_%0d: vec=%b data=%b cnt=%0d val=%b busy=%b done=%b nf=%b, need all 0",
                               i, o_vec[i], o_data[i], o_cnt[i], o_val[i], o_busy[i], o_done[i], o_nf[i]);
         end
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_ref_eval();     run_sweep(0, 1, ref_table(), 0, 1'b0, "ref_eval");   endtask
   task automatic test_zero();         run_sweep(0, 1, 8'h00, 0, 1'b0, "zero");            endtask
   task automatic test_all_ones_stall(); run_sweep(0, 1, 8'hFF, 1, 1'b0, "ones_stall");    endtask
   task automatic test_settle3();      run_sweep(1, 3, 8'h00, 0, 1'b0, "settle3");         endtask
   task automatic test_start_ignored(); run_sweep(0, 1, ref_table(), 0, 1'b1, "start_ignored"); endtask

   task automatic test_random();
      for (int k = 0; k < 4; k++) run_sweep(0, 1, 8'($urandom), 2, 1'b0, "random");
   endtask

   task automatic test_reset_mid_emit();
      bit hit;
      tt_a = ref_table(); ready_v[0] = 1'b1; hit = 1'b0;
      @(negedge clk); start_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0;
      for (int t = 0; t < 100 && !hit; t++) begin
         if (val_a === 1'b1 && data_a === 3'b010) begin
            ready_v[0] = 1'b0; hit = 1'b1;
         end else begin
            ready_v[0] = 1'b1;
            @(negedge clk);
         end
      end
      n_chk++;
      if (!hit) begin
         n_fail++; $display("FAIL rst_emit reach: no stall on 010, need one");
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if ({vec_a, data_a, cnt_a, val_a, busy_a, done_a, nf_a} !== 17'd0) begin
         n_fail++; $display("FAIL rst_emit async: vec=%b data=%b cnt=%0d val=%b busy=%b done=%b, need all 0",
                            vec_a, data_a, cnt_a, val_a, busy_a, done_a);
      end
      @(negedge clk); rst = 1'b0; ready_v[0] = 1'b1;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         n_chk++;
         if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL rst_emit idle: busy=%b done=%b, need 0 0", busy_a, done_a);
         end
      end
      run_sweep(0, 1, ref_table(), 0, 1'b0, "rst_restart");
   endtask

   initial begin
      test_reset();
      test_ref_eval();
      test_zero();
      test_all_ones_stall();
      test_settle3();
      test_reset_mid_emit();
      test_start_ignored();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bdiff_sweep_ctrl.md
# bdiff_sweep_ctrl

Sequencer that drives an external combinational Boolean-difference evaluator through all 2^N_VARS input vectors. It waits a programmable settle time per vector, samples the single-bit result, and streams every vector that produced a 1 out over a valid/ready port. It also reports a match count. It sits between the evaluator netlist and the result collector, and replaces the bench-only exhaustive `for` loop with synthesizable, back-pressured hardware.

## Interface
- N_VARS, 3, number of evaluator inputs; the sweep covers 0 .. 2^N_VARS-1.
- SETTLE_CYCLES, 1, cycles each vector is held before sampling; minimum 1.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  sweep request; sampled only in IDLE.
- vec_out  out  N_VARS  vector applied to evaluator inputs, MSB-first ordering matching the evaluator port list.
- f_in  in  1  evaluator result for vec_out.
- match_valid  out  1  match_data holds a matching vector.
- match_ready  in  1  collector accepts; a transfer occurs when valid && ready.
- match_data  out  N_VARS  matching vector.
- match_count  out  N_VARS+1  matches transferred in the current or last sweep.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sweep end.
- none_found  out  1  set with done when match_count==0; cleared on next accepted start.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, EMIT, DONE.
- IDLE: if start==1, then vec_out<=0, match_count<=0, none_found<=0, settle counter<=0, and the FSM goes to APPLY. start is ignored in every other state.
- APPLY: hold vec_out and count settle cycles. After SETTLE_CYCLES cycles in APPLY, go to SAMPLE.
- SAMPLE: register f_in.
  - If f_in==1, load match_data<=vec_out and go to EMIT.
  - Else if vec_out is all ones, go to DONE.
  - Else vec_out<=vec_out+1, clear the settle counter, and go to APPLY.
- EMIT: match_valid=1 and match_data stays stable until the transfer. On transfer, match_count increments, then the FSM takes the same last-vector/advance decision as SAMPLE. match_valid must not drop without a transfer.
- DONE: done=1 for exactly one cycle; none_found<=(match_count==0); then IDLE.
- Arithmetic: vec_out is an unsigned N_VARS counter and the sweep terminates on all ones, so it never wraps. match_count is N_VARS+1 bits wide and cannot overflow, because it holds at most 2^N_VARS matches.
- match_count and none_found hold their values in IDLE until the next accepted start.
- start asserted in the same cycle as DONE is ignored; it is honored only in IDLE.

## Timing
- Reset values: state IDLE; vec_out=0, match_data=0, match_count=0; match_valid=0, busy=0, done=0, none_found=0.
- start is accepted at edge k. busy=1 and vec_out=0 appear from cycle k+1.
- Per non-matching vector: SETTLE_CYCLES+1 cycles.
- Per matching vector: SETTLE_CYCLES+1 cycles plus the EMIT cycles. EMIT lasts at least 1 cycle, or more while match_ready is low.
- Zero-match sweep: done asserts 2^N_VARS·(SETTLE_CYCLES+1) cycles after busy rises.
- match_ready held high means each match costs exactly one extra cycle.
- Reset asserted mid-sweep: all outputs return immediately, asynchronously, to their reset values. Any pending match is dropped and no done pulse is generated.

## Structure
- Package bdiff_pkg holds:
  - the state enum (IDLE, APPLY, SAMPLE, EMIT, DONE);
  - the width function for the settle counter, $clog2(SETTLE_CYCLES+1);
  - the default N_VARS constant.
- Sub-module bdiff_settle_timer is natural. It has load, expire and a parameterized count, and is instantiated once.
- The evaluator itself is not part of this block. Benches instantiate the evaluator alongside this block and wire vec_out to it as {Cin,A,B}.

## Test plan
- Reference evaluator, (A^B)&dCout/dCin, with N_VARS=3, SETTLE_CYCLES=1 and match_ready tied high. Pulse start. Required response:
  - match_data sequence 001, 010, 101, 110;
  - match_count=4, none_found=0;
  - done exactly one cycle, 8·2+4=20 cycles after busy rises.
- Evaluator tied to 0. Required response: no match_valid ever; done after 16 cycles; match_count=0; none_found=1.
- Evaluator tied to 1, with match_ready low for 3 cycles on every match. Required response:
  - 8 matches, 000..111 in order;
  - match_data stable while valid && !ready;
  - match_count=8.
- SETTLE_CYCLES=3 with the evaluator tied to 0. Required response: each vec_out value is held 4 cycles; done after 32 cycles.
- Assert rst while EMIT is stalled on vector 010. Required response:
  - all outputs are 0 before the next edge;
  - FSM in IDLE;
  - a new start restarts the sweep from 000.
- Assert start while busy and in the DONE cycle. Required response: ignored, with no restart and match_count unchanged.
